// File: rtl/modmul_wlm_stream.sv
// -----------------------------------------------------------------------------
// modmul_wlm_stream
//
// Streaming multi-modulus word-level Montgomery multiplier.
//   out_t = A * B * 2^(-LOGQ) mod q,  q = {qH, LOGW'b0} + 1
// qH is taken per item from a runtime-loadable table of NQ entries.
//
// Pipeline (never stalls):
//   stage 0        : A, B, qH, tag, err registered at acceptance
//   stage 1        : C = A * B
//   stages 2..K+1  : one LOGW-bit reduction step each
//   final          : optional conditional subtraction, written into the FIFO
// An item accepted at edge n shows up at the head of an empty FIFO after
// edge n + K + 2.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   cfg_we/idx/qh         modulus table write (idx >= NQ ignored)
//   in_valid/in_ready     operand handshake
//   in_a, in_b            operands (< selected q)
//   in_qsel               table select (>= NQ -> entry 0 and out_err=1)
//   in_tag                sideband, returned unchanged
//   out_valid/out_ready   result handshake
//   out_t, out_tag        result and its tag
//   out_err               in_qsel was out of range for this result
//
// Handshake semantics (both sides): a transfer happens at a rising edge where
// valid and ready are both 1. The producer holds its payload stable while
// valid=1 and ready=0. in_ready depends only on registered state (credit
// counter), never combinationally on in_valid or out_ready.
// -----------------------------------------------------------------------------
module modmul_wlm_stream #(
  parameter int LOGQ       = 32,
  parameter int LOGW       = 16,
  parameter int LOGQH      = LOGQ - LOGW,
  parameter int NQ         = 4,
  parameter int QSELW      = (NQ > 2) ? $clog2(NQ) : 1,
  parameter int TAGW       = 8,
  parameter int OBUF_DEPTH = 8,
  parameter int CORRECT    = 1,
  localparam int LOGT      = (CORRECT != 0) ? LOGQ : LOGQ + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_we,
  input  logic [QSELW-1:0] cfg_idx,
  input  logic [LOGQH-1:0] cfg_qh,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [LOGQ-1:0]  in_a,
  input  logic [LOGQ-1:0]  in_b,
  input  logic [QSELW-1:0] in_qsel,
  input  logic [TAGW-1:0]  in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [LOGT-1:0]  out_t,
  output logic [TAGW-1:0]  out_tag,
  output logic             out_err
);

  localparam int K    = LOGQ / LOGW;
  localparam int LAT  = K + 2;
  localparam int LS   = LAT - 1;            // index of the last reduction stage
  localparam int CW   = 2 * LOGQ;           // holds A*B and every reduced C'
  localparam int PW   = LOGQ + 1;           // pre-correction value is < 2q
  localparam int CNTW = $clog2(OBUF_DEPTH + 1);
  localparam int AW   = (OBUF_DEPTH > 1) ? $clog2(OBUF_DEPTH) : 1;
  localparam int FW   = LOGT + TAGW + 1;

  localparam logic [QSELW:0]  NQ_V    = (QSELW + 1)'(NQ);
  localparam logic [CNTW-1:0] DEPTH_V = CNTW'(OBUF_DEPTH);

  // ---------------------------------------------------------------------------
  // Modulus table
  // ---------------------------------------------------------------------------
  logic [LOGQH-1:0] r_tab [NQ];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NQ; i++) r_tab[i] <= '0;
    end else if (cfg_we && ({1'b0, cfg_idx} < NQ_V)) begin
      r_tab[cfg_idx] <= cfg_qh;
    end
  end

  // ---------------------------------------------------------------------------
  // Credits and acceptance
  // ---------------------------------------------------------------------------
  logic [CNTW-1:0]  r_cnt;     // items in flight + FIFO occupancy
  logic             w_acc;
  logic             w_pop;
  logic             w_sel_ok;
  logic [QSELW-1:0] w_idx;
  logic [LOGQH-1:0] w_qh;

  assign in_ready = (r_cnt < DEPTH_V);
  assign w_acc    = in_valid & in_ready;
  assign w_sel_ok = ({1'b0, in_qsel} < NQ_V);
  assign w_idx    = w_sel_ok ? in_qsel : '0;
  // Read before any same-edge table write lands, so a same-edge rewrite of
  // this entry is not seen by the accepted item.
  assign w_qh     = r_tab[w_idx];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else begin
      case ({w_acc, w_pop})
        2'b10:   r_cnt <= r_cnt + CNTW'(1);
        2'b01:   r_cnt <= r_cnt - CNTW'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 0: operand capture
  // ---------------------------------------------------------------------------
  logic             r_v0;
  logic [LOGQ-1:0]  r_a;
  logic [LOGQ-1:0]  r_b;
  logic [LOGQH-1:0] r_qh0;
  logic [TAGW-1:0]  r_tag0;
  logic             r_err0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v0   <= 1'b0;
      r_a    <= '0;
      r_b    <= '0;
      r_qh0  <= '0;
      r_tag0 <= '0;
      r_err0 <= 1'b0;
    end else begin
      r_v0 <= w_acc;
      if (w_acc) begin
        r_a    <= in_a;
        r_b    <= in_b;
        r_qh0  <= w_qh;
        r_tag0 <= in_tag;
        r_err0 <= ~w_sel_ok;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stages 1..LS: product then K reduction steps
  // ---------------------------------------------------------------------------
  logic             r_v   [1:LS];
  logic [CW-1:0]    r_c   [1:LS];
  logic [LOGQH-1:0] r_qh  [1:LS];
  logic [TAGW-1:0]  r_tag [1:LS];
  logic             r_err [1:LS];

  logic [CW-1:0]    w_prod;
  logic [LOGW-1:0]  w_cl  [2:LS];
  logic [LOGW-1:0]  w_m   [2:LS];
  logic [CW-1:0]    w_red [2:LS];

  assign w_prod = CW'(r_a) * CW'(r_b);

  // One step: adding m*q clears the low word. Since q = qH*2^LOGW + 1,
  // (C + m*q) >> LOGW = (C >> LOGW) + qH*m + carry, and the carry out of
  // CL + m is 1 exactly when CL != 0.
  always_comb begin
    for (int j = 2; j <= LS; j++) begin
      w_cl[j]  = r_c[j-1][LOGW-1:0];
      w_m[j]   = '0 - w_cl[j];
      w_red[j] = (r_c[j-1] >> LOGW)
               + (CW'(r_qh[j-1]) * CW'(w_m[j]))
               + CW'(w_cl[j] != '0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int j = 1; j <= LS; j++) begin
        r_v[j]   <= 1'b0;
        r_c[j]   <= '0;
        r_qh[j]  <= '0;
        r_tag[j] <= '0;
        r_err[j] <= 1'b0;
      end
    end else begin
      r_v[1]   <= r_v0;
      r_c[1]   <= w_prod;
      r_qh[1]  <= r_qh0;
      r_tag[1] <= r_tag0;
      r_err[1] <= r_err0;
      for (int j = 2; j <= LS; j++) begin
        r_v[j]   <= r_v[j-1];
        r_c[j]   <= w_red[j];
        r_qh[j]  <= r_qh[j-1];
        r_tag[j] <= r_tag[j-1];
        r_err[j] <= r_err[j-1];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Final correction
  // ---------------------------------------------------------------------------
  logic [PW-1:0]   w_pre;
  logic [PW-1:0]   w_q;
  logic [LOGT-1:0] w_res;

  assign w_pre = PW'(r_c[LS]);              // upper bits are zero for legal operands
  assign w_q   = {1'b0, r_qh[LS], {LOGW{1'b0}}} + PW'(1);

  generate
    if (CORRECT != 0) begin : g_corr
      logic [PW-1:0] w_sub;
      assign w_sub = (w_pre >= w_q) ? (w_pre - w_q) : w_pre;
      assign w_res = LOGT'(w_sub);
    end else begin : g_raw
      assign w_res = LOGT'(w_pre);
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Output FIFO (first-word fall-through). Credits guarantee it never
  // receives a push while full.
  // ---------------------------------------------------------------------------
  logic [FW-1:0]   r_mem [OBUF_DEPTH];
  logic [AW-1:0]   r_wptr;
  logic [AW-1:0]   r_rptr;
  logic [CNTW-1:0] r_fcnt;
  logic            w_push;
  logic [FW-1:0]   w_head;

  function automatic logic [AW-1:0] f_inc(input logic [AW-1:0] p);
    return (p == AW'(OBUF_DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign w_push    = r_v[LS];
  assign out_valid = (r_fcnt != '0);
  assign w_pop     = out_valid & out_ready;

  // Storage needs no reset: the pointers and occupancy define what is valid.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= {w_res, r_tag[LS], r_err[LS]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_fcnt <= '0;
    end else begin
      if (w_push) r_wptr <= f_inc(r_wptr);
      if (w_pop)  r_rptr <= f_inc(r_rptr);
      case ({w_push, w_pop})
        2'b10:   r_fcnt <= r_fcnt + CNTW'(1);
        2'b01:   r_fcnt <= r_fcnt - CNTW'(1);
        default: r_fcnt <= r_fcnt;
      endcase
    end
  end

  assign w_head  = r_mem[r_rptr];
  assign out_t   = w_head[FW-1 -: LOGT];
  assign out_tag = w_head[TAGW:1];
  // Gated so the flag reads 0 whenever nothing is presented (incl. reset).
  assign out_err = out_valid & w_head[0];

endmodule

// File: tb/tb_modmul_wlm_stream.sv
// Bench for modmul_wlm_stream. Two instances share all inputs: one with the
// final correction (CORRECT=1) and one without (CORRECT=0). NQ=5 so that
// in_qsel values 5..7 exist and exercise the out-of-range path.
module tb_modmul_wlm_stream;

  localparam int EW = 8 + 1 + 32 + 32;       // {tag, err, result, q}
  localparam logic [31:0] Q1 = 32'hFFFF0001;
  localparam logic [31:0] QC = 32'hC0000001;
  localparam logic [31:0] Q0 = 32'hF0000001;

  // ---------------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------------
  logic        clk = 1'b0;
  logic        rst_n;
  logic        cfg_we;
  logic [2:0]  cfg_idx;
  logic [15:0] cfg_qh;
  logic        in_valid;
  logic [31:0] in_a, in_b;
  logic [2:0]  in_qsel;
  logic [7:0]  in_tag;
  logic        out_ready = 1'b0;

  logic        in_ready1, out_valid1, out_err1;
  logic [31:0] out_t1;
  logic [7:0]  out_tag1;
  logic        in_ready0, out_valid0, out_err0;
  logic [32:0] out_t0;
  logic [7:0]  out_tag0;

  always #5 clk = ~clk;

  modmul_wlm_stream #(.NQ(5), .CORRECT(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_qh(cfg_qh),
    .in_valid(in_valid), .in_ready(in_ready1), .in_a(in_a), .in_b(in_b),
    .in_qsel(in_qsel), .in_tag(in_tag), .out_valid(out_valid1), .out_ready(out_ready),
    .out_t(out_t1), .out_tag(out_tag1), .out_err(out_err1)
  );

  modmul_wlm_stream #(.NQ(5), .CORRECT(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_qh(cfg_qh),
    .in_valid(in_valid), .in_ready(in_ready0), .in_a(in_a), .in_b(in_b),
    .in_qsel(in_qsel), .in_tag(in_tag), .out_valid(out_valid0), .out_ready(out_ready),
    .out_t(out_t0), .out_tag(out_tag0), .out_err(out_err0)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard state and checkers
  // ---------------------------------------------------------------------------
  logic [EW-1:0] exp_q[$];
  int n_cmp = 0;
  int n_fail = 0;
  int n_stall = 0;
  bit rand_rdy = 1'b0;
  bit rdy_fixed = 1'b1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic chk_ok(input string nm, input bit ok, input logic [63:0] act,
                        input logic [63:0] ref_v);
    n_cmp++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %0h reference %0h", nm, act, ref_v);
    end
  endtask

  // Independent reference: (A*B mod q) halved modulo q LOGQ times.
  function automatic logic [31:0] mont_ref(input logic [31:0] a, b, q);
    logic [63:0] p;
    logic [32:0] x;
    p = ({32'b0, a} * {32'b0, b}) % {32'b0, q};
    x = 33'(p);
    for (int i = 0; i < 32; i++) x = x[0] ? ((x + {1'b0, q}) >> 1) : (x >> 1);
    return x[31:0];
  endfunction

  // ---------------------------------------------------------------------------
  // Output sink readiness (single driver)
  // ---------------------------------------------------------------------------
  always @(posedge clk) begin
    #1;
    out_ready = rand_rdy ? 1'($urandom_range(0, 1)) : rdy_fixed;
  end

  // ---------------------------------------------------------------------------
  // Monitor: compares whenever a pop will happen at the next edge
  // ---------------------------------------------------------------------------
  logic [EW-1:0] m_e;
  logic [7:0]    m_tag;
  logic          m_err;
  logic [31:0]   m_r, m_q;

  always @(negedge clk) begin
    if (rst_n === 1'b1 && out_ready && out_valid1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_output: got t=%0h tag=%0h want none", out_t1, out_tag1);
      end else begin
        m_e = exp_q.pop_front();
        {m_tag, m_err, m_r, m_q} = m_e;
        chk("t_c1", out_t1, m_r);
        chk("tag_c1", out_tag1, m_tag);
        chk("err_c1", out_err1, m_err);
        chk_ok("t_c1_lt_q", out_t1 < m_q, out_t1, m_q);
        chk("valid_c0", out_valid0, 1);
        chk("tag_c0", out_tag0, m_tag);
        chk("err_c0", out_err0, m_err);
        chk_ok("t_c0_congruent", (out_t0 == {1'b0, m_r}) || (out_t0 == {1'b0, m_r} + {1'b0, m_q}),
               out_t0, m_r);
        chk_ok("t_c0_lt_2q", out_t0 < {m_q, 1'b0}, out_t0, {m_q, 1'b0});
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic cfg_write(input logic [2:0] idx, input logic [15:0] val);
    @(negedge clk);
    cfg_we = 1'b1; cfg_idx = idx; cfg_qh = val;
    @(posedge clk);
    #1 cfg_we = 1'b0;
  endtask

  task automatic send(input logic [31:0] a, b, input logic [2:0] qs, input logic [7:0] tg,
                      input logic er, input logic [31:0] r, q);
    int w = 0;
    @(negedge clk);
    in_valid = 1'b1; in_a = a; in_b = b; in_qsel = qs; in_tag = tg;
    while (!in_ready1 && w < 300) begin
      n_stall++;
      w++;
      @(negedge clk);
    end
    if (!in_ready1) begin
      n_cmp++;
      n_fail++;
      $display("FAIL accept_timeout: got in_ready=0 want 1 (tag %0h)", tg);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    exp_q.push_back({tg, er, r, q});
    #1 in_valid = 1'b0;
  endtask

  task automatic set_rdy(input bit v);
    rdy_fixed = v;
    @(posedge clk);
    #2;
  endtask

  task automatic wait_empty(input string nm);
    int n = 0;
    while (exp_q.size() != 0 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s: got %0d results outstanding want 0", nm, exp_q.size());
    end
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  int lat, k, s;
  bit rdy;
  logic [31:0] qv [1:4];
  logic [31:0] ra, rb, rq;

  initial begin
    rst_n = 1'b0; cfg_we = 1'b0; cfg_idx = '0; cfg_qh = '0;
    in_valid = 1'b0; in_a = '0; in_b = '0; in_qsel = '0; in_tag = '0;
    #3;
    chk("rst_in_ready_c1", in_ready1, 1);
    chk("rst_out_valid_c1", out_valid1, 0);
    chk("rst_out_err_c1", out_err1, 0);
    chk("rst_in_ready_c0", in_ready0, 1);
    chk("rst_out_valid_c0", out_valid0, 0);
    chk("rst_out_err_c0", out_err0, 0);
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    // First item and latency
    cfg_write(3'd1, 16'hFFFF);
    send(32'h1, 32'hFFFF, 3'd1, 8'h5A, 1'b0, 32'h1, Q1);
    lat = 0;
    while (!out_valid1 && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("latency", lat, 4);

    // Directed vectors, q = 0xFFFF0001 (2^32 mod q = 0xFFFF)
    send(32'hFFFF, 32'hFFFF, 3'd1, 8'h01, 1'b0, 32'hFFFF, Q1);
    send(32'hFFFF0000, 32'hFFFF, 3'd1, 8'h02, 1'b0, 32'hFFFF0000, Q1);
    send(32'h0, 32'h12345678, 3'd1, 8'h03, 1'b0, 32'h0, Q1);
    wait_empty("directed_drain");

    // Fill against a stalled sink: credits cap acceptance at the buffer depth
    set_rdy(1'b0);
    k = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      in_valid = 1'b1; in_a = 32'hFFFF; in_b = 32'(k + 1); in_qsel = 3'd1;
      in_tag = 8'(8'h10 + k);
      rdy = in_ready1;
      @(posedge clk);
      if (rdy) begin
        exp_q.push_back({8'(8'h10 + k), 1'b0, 32'(k + 1), Q1});
        k++;
      end
    end
    #1 in_valid = 1'b0;
    chk("accepted_when_full", k, 8);
    @(negedge clk);
    chk("in_ready_full", in_ready1, 0);
    set_rdy(1'b1);
    @(negedge clk);
    chk("in_ready_before_pop", in_ready1, 0);
    @(negedge clk);
    chk("in_ready_after_pop", in_ready1, 1);
    wait_empty("full_drain");

    // Back-to-back stream with an always-ready sink
    n_stall = 0;
    for (int i = 0; i < 10; i++)
      send(32'hFFFF, 32'(100 + i), 3'd1, 8'(8'h30 + i), 1'b0, 32'(100 + i), Q1);
    chk("b2b_stalls", n_stall, 0);
    wait_empty("b2b_drain");

    // Table rewrite on the same edge as an accept of that entry
    @(negedge clk);
    cfg_we = 1'b1; cfg_idx = 3'd1; cfg_qh = 16'hC000;
    in_valid = 1'b1; in_a = 32'hFFFF; in_b = 32'h55; in_qsel = 3'd1; in_tag = 8'h70;
    chk("in_ready_cfg_acc", in_ready1, 1);
    @(posedge clk);
    exp_q.push_back({8'h70, 1'b0, 32'h55, Q1});
    #1 begin cfg_we = 1'b0; in_valid = 1'b0; end
    send(32'h3FFFFFFF, 32'h66, 3'd1, 8'h71, 1'b0, 32'h66, QC);

    // Out-of-range select uses entry 0; writes to idx >= NQ are ignored
    cfg_write(3'd0, 16'hF000);
    cfg_write(3'd5, 16'h1234);
    cfg_write(3'd7, 16'h0001);
    send(32'h0FFFFFFF, 32'h1234, 3'd5, 8'h80, 1'b1, 32'h1234, Q0);
    send(32'h0FFFFFFF, 32'h4321, 3'd0, 8'h81, 1'b0, 32'h4321, Q0);
    send(32'h0FFFFFFF, 32'h0BEE, 3'd7, 8'h82, 1'b1, 32'h0BEE, Q0);
    wait_empty("err_drain");

    // Reset with 2 results buffered and 3 in flight
    set_rdy(1'b0);
    send(32'h3FFFFFFF, 32'h5, 3'd1, 8'hA0, 1'b0, 32'h5, QC);
    send(32'h3FFFFFFF, 32'h6, 3'd1, 8'hA1, 1'b0, 32'h6, QC);
    repeat (6) @(negedge clk);
    send(32'h3FFFFFFF, 32'h7, 3'd1, 8'hA2, 1'b0, 32'h7, QC);
    send(32'h3FFFFFFF, 32'h8, 3'd1, 8'hA3, 1'b0, 32'h8, QC);
    send(32'h3FFFFFFF, 32'h9, 3'd1, 8'hA4, 1'b0, 32'h9, QC);
    rst_n = 1'b0;
    #1;
    chk("midrst_in_ready", in_ready1, 1);
    chk("midrst_out_valid_c1", out_valid1, 0);
    chk("midrst_out_err_c1", out_err1, 0);
    chk("midrst_out_valid_c0", out_valid0, 0);
    exp_q.delete();
    set_rdy(1'b1);
    @(negedge clk) rst_n = 1'b1;
    repeat (12) @(negedge clk);
    chk("post_reset_idle", out_valid1, 0);
    // Table cleared: qH=0 means q=1, so A=B=1 reduces to 0 (raw value 1).
    send(32'h1, 32'h1, 3'd1, 8'hB0, 1'b0, 32'h0, 32'h1);
    send(32'h1, 32'h1, 3'd0, 8'hB1, 1'b0, 32'h0, 32'h1);
    wait_empty("post_reset_drain");

    // Random operands over 4 moduli with a random sink
    qv[1] = 32'hFFFF0001; qv[2] = 32'hC0000001; qv[3] = 32'h80010001; qv[4] = 32'h12350001;
    for (int i = 1; i <= 4; i++) cfg_write(3'(i), qv[i][31:16]);
    rand_rdy = 1'b1;
    for (int i = 0; i < 40; i++) begin
      s  = $urandom_range(1, 4);
      rq = qv[s];
      ra = $urandom % rq;
      rb = $urandom % rq;
      send(ra, rb, 3'(s), 8'(8'hC0 + i), 1'b0, mont_ref(ra, rb, rq), rq);
    end
    rand_rdy = 1'b0;
    set_rdy(1'b1);
    wait_empty("random_drain");
    repeat (5) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    n_cmp++;
    n_fail++;
    $display("FAIL watchdog: got timeout want completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
